// File: rtl/mpdmac_cfg.sv
// APB3 configuration/launch register file for the MPDMAC engine.
// Optional completion interrupt is built when MPDMAC_IRQ_EN is defined.
module mpdmac_cfg #(
  parameter logic [31:0] VERSION = 32'h0001_2024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [11:0] paddr_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic [31:0] src_addr_o,
  output logic [31:0] dst_addr_o,
  output logic [5:0]  mat_width_o,
  output logic        start_o,
  input  logic        done_i,
  output logic        irq_o
);

  localparam logic [9:0] A_VERSION = 10'h000;
  localparam logic [9:0] A_SRC     = 10'h040;
  localparam logic [9:0] A_DST     = 10'h041;
  localparam logic [9:0] A_WIDTH   = 10'h042;
  localparam logic [9:0] A_START   = 10'h043;
  localparam logic [9:0] A_STATUS  = 10'h044;
  localparam logic [9:0] A_IRQ_EN  = 10'h045;
  localparam logic [9:0] A_IRQ_STS = 10'h046;

  logic [31:0] r_prdata;
  logic [31:0] r_src;
  logic [31:0] r_dst;
  logic [5:0]  r_width;
  logic        r_start;
  logic        r_start_pend;

  logic [9:0]  w_word;
  logic        w_wr;
  logic        w_busy;
  logic        w_width_ok;
  logic        w_start_req;
  logic        w_start_acc;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_word      = paddr_i[11:2];
  assign w_unused    = &{1'b0, paddr_i[1:0]};
  assign w_wr        = psel_i & penable_i & pwrite_i;
  // r_start is included so a read captured during the pulse cycle already reports busy.
  assign w_busy      = r_start_pend | r_start | ~done_i;
  assign w_width_ok  = ~r_width[0] & (r_width >= 6'd2) & (r_width <= 6'd30);
  assign w_start_req = w_wr & (w_word == A_START) & pwdata_i[0];
  assign w_start_acc = w_start_req & ~w_busy & w_width_ok;

  assign pready_o    = 1'b1;
  assign pslverr_o   = w_start_req & ~w_start_acc;
  assign prdata_o    = r_prdata;
  assign src_addr_o  = r_src;
  assign dst_addr_o  = r_dst;
  assign mat_width_o = r_width;
  assign start_o     = r_start;

`ifdef MPDMAC_IRQ_EN
  logic r_done_q;
  logic r_launched;
  logic r_irq_en;
  logic r_irq_sts;
  logic r_irq;
  logic w_done_rise;
  logic w_irq_en_nxt;
  logic w_irq_sts_nxt;

  assign w_done_rise = done_i & ~r_done_q & r_launched;
  assign irq_o       = r_irq;

  // Next-state of interrupt enable/status; a completion edge beats a same-cycle clear.
  always_comb begin
    w_irq_en_nxt  = r_irq_en;
    w_irq_sts_nxt = r_irq_sts;
    if (w_wr && (w_word == A_IRQ_EN)) begin
      w_irq_en_nxt = pwdata_i[0];
    end else begin
      w_irq_en_nxt = r_irq_en;
    end
    if (w_done_rise) begin
      w_irq_sts_nxt = 1'b1;
    end else if (w_wr && (w_word == A_IRQ_STS) && pwdata_i[0]) begin
      w_irq_sts_nxt = 1'b0;
    end else begin
      w_irq_sts_nxt = r_irq_sts;
    end
  end

  // Completion tracking and interrupt state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_q   <= 1'b1;
      r_launched <= 1'b0;
      r_irq_en   <= 1'b0;
      r_irq_sts  <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_done_q  <= done_i;
      r_irq_en  <= w_irq_en_nxt;
      r_irq_sts <= w_irq_sts_nxt;
      r_irq     <= w_irq_en_nxt & w_irq_sts_nxt;
      if (r_start) begin
        r_launched <= 1'b1;
      end else if (w_done_rise) begin
        r_launched <= 1'b0;
      end
    end
  end
`else
  assign irq_o = 1'b0;
`endif

  // Register read multiplexer.
  always_comb begin
    w_rdata = 32'd0;
    case (w_word)
      A_VERSION: w_rdata = VERSION;
      A_SRC:     w_rdata = r_src;
      A_DST:     w_rdata = r_dst;
      A_WIDTH:   w_rdata = {26'd0, r_width};
      A_STATUS:  w_rdata = {31'd0, ~w_busy};
`ifdef MPDMAC_IRQ_EN
      A_IRQ_EN:  w_rdata = {31'd0, r_irq_en};
      A_IRQ_STS: w_rdata = {31'd0, r_irq_sts};
`endif
      default:   w_rdata = 32'd0;
    endcase
  end

  // Read data captured in setup phase, held through access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prdata <= 32'd0;
    end else if (psel_i && !penable_i) begin
      r_prdata <= pwrite_i ? 32'd0 : w_rdata;
    end
  end

  // Engine configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src   <= 32'd0;
      r_dst   <= 32'd0;
      r_width <= 6'd0;
    end else if (w_wr) begin
      if (w_word == A_SRC)   r_src   <= pwdata_i;
      if (w_word == A_DST)   r_dst   <= pwdata_i;
      if (w_word == A_WIDTH) r_width <= pwdata_i[5:0];
    end
  end

  // Launch pulse; start_pend bridges the engine's latency in dropping done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start      <= 1'b0;
      r_start_pend <= 1'b0;
    end else begin
      r_start <= w_start_acc;
      if (r_start) begin
        r_start_pend <= 1'b1;
      end else if (!done_i) begin
        r_start_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mpdmac_cfg.sv
// Directed self-checking bench for mpdmac_cfg with a small engine model.
module tb_mpdmac_cfg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic [11:0] paddr = 12'd0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = 32'd0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [5:0]  mat_width;
  logic        start_o;
  logic        done_i = 1'b1;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulse  = 0;
  int eng_cnt  = 0;
  int eng_len  = 4;
  bit rel_req  = 1'b0;

  mpdmac_cfg dut (
    .clk(clk), .rst_n(rst_n), .psel_i(psel), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .src_addr_o(src_addr), .dst_addr_o(dst_addr), .mat_width_o(mat_width),
    .start_o(start_o), .done_i(done_i), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // Engine model: drops done the cycle after start, raises it after eng_len cycles
  // (eng_len==0 holds it low until rel_req).
  always @(posedge clk) begin
    if (start_o) begin
      done_i  <= 1'b0;
      eng_cnt <= eng_len;
    end else if (rel_req) begin
      done_i  <= 1'b1;
      eng_cnt <= 0;
    end else if (eng_cnt == 1) begin
      done_i  <= 1'b1;
      eng_cnt <= 0;
    end else if (eng_cnt > 1) begin
      eng_cnt <= eng_cnt - 1;
    end
  end

  always @(posedge clk) if (start_o) n_pulse <= n_pulse + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input bit rel, output bit err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; rel_req = rel;
    @(posedge clk); #1;
    penable = 1'b1; rel_req = 1'b0;
    @(negedge clk);
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output bit err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    d = prdata; err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Waits (bounded) for done to drop and then rise; returns on the rise-cycle negedge.
  task automatic wait_engine();
    for (int i = 0; i < 40 && done_i; i++) @(negedge clk);
    for (int i = 0; i < 100 && !done_i; i++) @(negedge clk);
    check_val("engine_done", {31'd0, done_i}, 32'd1);
  endtask

  logic [31:0] rd;
  bit          err;
  int          p0;
  logic [5:0]  w_tab [5] = '{6'd7, 6'd0, 6'd32, 6'd30, 6'd2};
  bit          e_tab [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    #7 rst_n = 1'b0;
    #1;
    check_val("rst_prdata", prdata, 32'd0);
    check_val("rst_pslverr", {31'd0, pslverr}, 32'd0);
    check_val("rst_pready", {31'd0, pready}, 32'd1);
    check_val("rst_src", src_addr, 32'd0);
    check_val("rst_dst", dst_addr, 32'd0);
    check_val("rst_width", {26'd0, mat_width}, 32'd0);
    check_val("rst_start", {31'd0, start_o}, 32'd0);
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    apb_read(12'h000, rd, err);
    check_val("version", rd, 32'h0001_2024);

    // Basic launch
    apb_write(12'h100, 32'h0000_1000, 1'b0, err);
    apb_write(12'h104, 32'h0000_2000, 1'b0, err);
    apb_write(12'h108, 32'd8, 1'b0, err);
    check_val("src_out", src_addr, 32'h0000_1000);
    check_val("dst_out", dst_addr, 32'h0000_2000);
    check_val("width_out", {26'd0, mat_width}, 32'd8);
    eng_len = 6;
    p0 = n_pulse;
    apb_write(12'h10C, 32'd1, 1'b0, err);
    check_val("start_ok_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    check_val("start_pulse", {31'd0, start_o}, 32'd1);
    apb_read(12'h110, rd, err);
    check_val("status_busy", rd, 32'd0);
    wait_engine();
    repeat (2) @(negedge clk);
    apb_read(12'h110, rd, err);
    check_val("status_idle", rd, 32'd1);
    check_val("one_pulse", n_pulse - p0, 32'd1);

    // START while busy
    eng_len = 20;
    p0 = n_pulse;
    apb_write(12'h10C, 32'd1, 1'b0, err);
    apb_write(12'h10C, 32'd1, 1'b0, err);
    check_val("busy_err", {31'd0, err}, 32'd1);
    wait_engine();
    check_val("busy_pulses", n_pulse - p0, 32'd1);

    // START bit0=0 is a no-op
    p0 = n_pulse;
    apb_write(12'h10C, 32'd0, 1'b0, err);
    repeat (2) @(negedge clk);
    check_val("start0_err", {31'd0, err}, 32'd0);
    check_val("start0_pulses", n_pulse - p0, 32'd0);

    apb_write(12'h108, 32'hFFFF_FFFF, 1'b0, err);
    apb_read(12'h108, rd, err);
    check_val("width_mask", rd, 32'h0000_003F);
    apb_write(12'h200, 32'h1234_5678, 1'b0, err);
    apb_read(12'h200, rd, err);
    check_val("unmapped_rd", rd, 32'd0);
    check_val("unmapped_err", {31'd0, err}, 32'd0);

    // Width boundaries
    eng_len = 4;
    for (int i = 0; i < 5; i++) begin
      apb_write(12'h108, {26'd0, w_tab[i]}, 1'b0, err);
      p0 = n_pulse;
      apb_write(12'h10C, 32'd1, 1'b0, err);
      check_val($sformatf("width%0d_err", w_tab[i]), {31'd0, err}, {31'd0, e_tab[i]});
      repeat (2) @(negedge clk);
      check_val($sformatf("width%0d_pulses", w_tab[i]), n_pulse - p0, e_tab[i] ? 32'd0 : 32'd1);
      if (!e_tab[i]) wait_engine();
      repeat (2) @(negedge clk);
    end

`ifdef MPDMAC_IRQ_EN
    apb_write(12'h114, 32'd1, 1'b0, err);
    apb_read(12'h114, rd, err);
    check_val("irq_en_rd", rd, 32'd1);
    eng_len = 4;
    apb_write(12'h10C, 32'd1, 1'b0, err);
    wait_engine();
    check_val("irq_rise_cyc", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check_val("irq_set", {31'd0, irq}, 32'd1);
    apb_write(12'h118, 32'd1, 1'b0, err);
    @(negedge clk);
    check_val("irq_w1c", {31'd0, irq}, 32'd0);
    apb_read(12'h118, rd, err);
    check_val("irq_sts_clr", rd, 32'd0);
    eng_len = 0;
    apb_write(12'h10C, 32'd1, 1'b0, err);
    repeat (4) @(negedge clk);
    apb_write(12'h118, 32'd1, 1'b1, err);
    @(negedge clk);
    check_val("irq_set_wins", {31'd0, irq}, 32'd1);
    apb_read(12'h118, rd, err);
    check_val("irq_sts_set", rd, 32'd1);
`else
    apb_write(12'h114, 32'd1, 1'b0, err);
    apb_read(12'h114, rd, err);
    check_val("noirq_114", rd, 32'd0);
    apb_read(12'h118, rd, err);
    check_val("noirq_118", rd, 32'd0);
    eng_len = 4;
    apb_write(12'h10C, 32'd1, 1'b0, err);
    wait_engine();
    repeat (3) @(negedge clk);
    check_val("noirq_irq", {31'd0, irq}, 32'd0);
`endif

    // Reset in the middle of a launch pulse
    eng_len = 0;
    apb_write(12'h100, 32'h0000_ABCD, 1'b0, err);
    apb_write(12'h10C, 32'd1, 1'b0, err);
    #2;
    check_val("pre_rst_start", {31'd0, start_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("async_rst_start", {31'd0, start_o}, 32'd0);
    check_val("async_rst_src", src_addr, 32'd0);
    check_val("async_rst_width", {26'd0, mat_width}, 32'd0);
    check_val("async_rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rel_req = 1'b1;
    @(posedge clk); #1;
    rel_req = 1'b0;
    apb_read(12'h110, rd, err);
    check_val("post_rst_status", rd, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
